// File: rtl/tinyriscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tinyriscv_pkg
// Description : Shared bus widths, the decode->execute payload struct, the
//               NOP encoding, the occupancy state encoding and the bubble
//               constructor used by the ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
package tinyriscv_pkg;

  localparam int InstBus     = 32;
  localparam int InstAddrBus = 32;
  localparam int MemAddrBus  = 32;
  localparam int RegBus      = 32;
  localparam int RegAddrBus  = 5;

  localparam logic WriteEnable = 1'b1;

  // addi x0, x0, 0
  localparam logic [InstBus-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [InstBus-1:0]     inst;
    logic [InstAddrBus-1:0] inst_addr;
    logic [RegBus-1:0]      op1;
    logic [RegBus-1:0]      op2;
    logic                   reg_we;
    logic [RegAddrBus-1:0]  reg_waddr;
    logic                   csr_we;
    logic [RegBus-1:0]      csr_rdata;
    logic [MemAddrBus-1:0]  csr_waddr;
    logic [2:0]             compare;
    logic [RegBus-1:0]      store_data;
  } id_ex_payload_t;

  // Number of entries held by the pipe; doubles as the buffer state.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // A NOP that writes nothing; the PC is carried over so execute still sees
  // where the bubble sits in program order.
  function automatic id_ex_payload_t id_ex_bubble(input logic [InstAddrBus-1:0] inst_addr);
    id_ex_payload_t b;
    b           = '0;
    b.inst      = INST_NOP;
    b.inst_addr = inst_addr;
    b.reg_we    = ~WriteEnable;
    b.csr_we    = ~WriteEnable;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_skid_buf
// Description : Generic two-entry payload buffer (head + skid registers plus
//               occupancy state). The head register is the visible output and
//               is loaded with fill_data whenever the buffer drains or clears,
//               so the consumer always sees a flop-driven value.
// Ports       : clk, rst (async, active-low)
//               push/push_data   - write a new entry (caller gates with not_full)
//               pop              - retire the head entry
//               clear            - discard all entries, head <= fill_data
//               fill_data        - value shown by the head while empty
//               head_data/valid  - registered head entry and its valid flag
//               not_full         - registered "can accept" flag
//               count            - registered occupancy (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_skid_buf
  import tinyriscv_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] push_data,
  input  logic [WIDTH-1:0] fill_data,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             not_full,
  output logic [1:0]       count
);

  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  occ_e             state, state_next;
  logic [WIDTH-1:0] head_q, head_next;
  logic [WIDTH-1:0] skid_q, skid_next;
  logic             valid_q;
  logic             not_full_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= OCC_EMPTY;
      head_q     <= RESET_VAL;
      skid_q     <= RESET_VAL;
      valid_q    <= 1'b0;
      not_full_q <= 1'b1;
    end else begin
      state      <= state_next;
      head_q     <= head_next;
      skid_q     <= skid_next;
      valid_q    <= (state_next != OCC_EMPTY);
      not_full_q <= (state_next != FULL_COUNT);
    end
  end

  always_comb begin
    state_next = state;
    head_next  = head_q;
    skid_next  = skid_q;
    if (clear) begin
      state_next = OCC_EMPTY;
      head_next  = fill_data;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (push) begin
            state_next = OCC_ONE;
            head_next  = push_data;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head_next = push_data;
          end else if (push) begin
            state_next = OCC_TWO;
            skid_next  = push_data;
          end else if (pop) begin
            state_next = OCC_EMPTY;
            head_next  = fill_data;
          end
        end
        OCC_TWO: begin
          // Pushes are blocked here by not_full; only a pop can advance.
          if (pop) begin
            state_next = OCC_ONE;
            head_next  = skid_q;
          end
        end
        default: begin
          state_next = OCC_EMPTY;
          head_next  = fill_data;
        end
      endcase
    end
  end

  assign head_data  = head_q;
  assign head_valid = valid_q;
  assign not_full   = not_full_q;
  assign count      = state;

endmodule
`default_nettype wire

// File: rtl/id_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe
// Description : Decode->execute pipeline register with valid/ready handshake,
//               flush (bubble insertion) and hold (freeze).
//               Build option macro ID_EX_SKID_EN: when defined, a two-entry
//               skid buffer is used and id_ready_o is registered; when
//               undefined, a single entry is used and id_ready_o is
//               ~ex_valid_o | ex_ready_i.
// Ports       : clk, rst (async, active-low)
//               id_valid_i/id_ready_o/id_payload_i   - decode side
//               ex_valid_o/ex_ready_i/ex_payload_o   - execute side
//               flush_i - kill all entries; hold_i - freeze the pipe
//               occupancy_o - entries currently held
// Parameter   : DEPTH_SKID - skid entry count, must be 2
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipe
  import tinyriscv_pkg::*;
#(
  parameter int unsigned DEPTH_SKID = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid_i,
  output logic           id_ready_o,
  input  id_ex_payload_t id_payload_i,
  output logic           ex_valid_o,
  input  logic           ex_ready_i,
  output id_ex_payload_t ex_payload_o,
  input  logic           flush_i,
  input  logic           hold_i,
  output logic [1:0]     occupancy_o
);

  localparam id_ex_payload_t RESET_PAYLOAD = id_ex_bubble({InstAddrBus{1'b0}});

  logic           in_fire;
  logic           out_fire;
  id_ex_payload_t fill_payload;

  // Flush and hold suppress both transfers; flush additionally clears.
  assign in_fire  = id_valid_i & id_ready_o & ~hold_i & ~flush_i;
  assign out_fire = ex_valid_o & ex_ready_i & ~hold_i & ~flush_i;

  // Bubble keeps the PC of whatever was last shown to execute.
  assign fill_payload = id_ex_bubble(ex_payload_o.inst_addr);

`ifdef ID_EX_SKID_EN

  logic [$bits(id_ex_payload_t)-1:0] head_bits;
  logic                              buf_not_full;

  id_ex_skid_buf #(
    .WIDTH     ($bits(id_ex_payload_t)),
    .DEPTH     (DEPTH_SKID),
    .RESET_VAL (RESET_PAYLOAD)
  ) u_skid_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (in_fire),
    .pop        (out_fire),
    .clear      (flush_i),
    .push_data  (id_payload_i),
    .fill_data  (fill_payload),
    .head_data  (head_bits),
    .head_valid (ex_valid_o),
    .not_full   (buf_not_full),
    .count      (occupancy_o)
  );

  assign ex_payload_o = id_ex_payload_t'(head_bits);
  assign id_ready_o   = buf_not_full;

`else

  logic           valid_q;
  id_ex_payload_t payload_q;
  logic           unused_depth;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      payload_q <= RESET_PAYLOAD;
    end else if (flush_i) begin
      valid_q   <= 1'b0;
      payload_q <= fill_payload;
    end else if (in_fire) begin
      // In this build an accept while full implies a simultaneous retire,
      // so the head is simply replaced.
      valid_q   <= 1'b1;
      payload_q <= id_payload_i;
    end else if (out_fire) begin
      valid_q   <= 1'b0;
      payload_q <= fill_payload;
    end
  end

  assign ex_valid_o   = valid_q;
  assign ex_payload_o = payload_q;
  // Not ready while reset is asserted.
  assign id_ready_o   = rst & (~valid_q | ex_ready_i);
  assign occupancy_o  = {1'b0, valid_q};

  // Skid depth has no meaning with a single entry.
  assign unused_depth = ^DEPTH_SKID;

`endif

endmodule
`default_nettype wire
